rgb_float_quantize: RTL and testbench

Parametrised successor to the fixed 4-bit RGB formatter. It converts NUM_CH IEEE-754 single-precision colour channels in [0,1] into OUT_BITS-bit unsigned pixel codes, with selectable truncate, round or 2x2 ordered-dither quantisation. Pixel coordinates and the visibility flag travel inside the pipeline with their data, so no fixed-delay side shift register is needed. It sits between the per-pixel colour shader and the framebuffer writer and supports valid/ready backpressure.

---
 rtl/rgb_fmt_pkg.sv | 50 +++++
 rtl/float_unorm_quant.sv | 109 ++++++++++
 rtl/rgb_float_quantize.sv | 123 ++++++++++++
 tb/tb_rgb_float_quantize.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_fmt_pkg.sv
// Shared definitions for the float-to-unorm pixel formatter: quantisation
// modes, IEEE-754 single-precision field layout and the 2x2 ordered-dither
// matrix, plus the per-pixel bias helper used by the top level.
package rgb_fmt_pkg;

    typedef enum logic [1:0] {
        Q_TRUNC  = 2'd0,
        Q_ROUND  = 2'd1,
        Q_DITHER = 2'd2
    } quant_mode_t;

    // Single-precision float layout.
    localparam int FP_W        = 32;
    localparam int FP_EXP_W    = 8;
    localparam int FP_MAN_W    = 23;
    localparam int FP_EXP_BIAS = 127;

    // Guard bits kept below the output LSB while adding the bias. Ten bits
    // hold the 1/2 and 1/4 step biases exactly and keep enough of the
    // mantissa that truncation below them never moves a code boundary the
    // bias could reach.
    localparam int BIAS_FRAC_W = 10;

    // Bayer 2x2 levels (in quarters of an LSB), packed two bits per entry.
    // Entry index is {y[0], x[0]}: 00 -> 0, 01 -> 2, 10 -> 3, 11 -> 1.
    localparam logic [7:0] BAYER_2X2 = {2'd1, 2'd3, 2'd2, 2'd0};

    // Half an output LSB expressed in guard-bit units.
    localparam logic [BIAS_FRAC_W-1:0] ROUND_BIAS = BIAS_FRAC_W'(1 << (BIAS_FRAC_W - 1));

    // Bias added to the scaled value before flooring, in guard-bit units.
    // Mode 3 is not a defined mode and falls through to truncate.
    function automatic logic [BIAS_FRAC_W-1:0] quant_bias(
        input logic [1:0] mode,
        input logic       x_lsb,
        input logic       y_lsb
    );
        logic [1:0]             level;
        logic [BIAS_FRAC_W-1:0] bias;
        level = BAYER_2X2[{y_lsb, x_lsb, 1'b0} +: 2];
        bias  = '0;
        case (mode)
            Q_ROUND:  bias = ROUND_BIAS;
            Q_DITHER: bias = {level, {(BIAS_FRAC_W - 2){1'b0}}};
            default:  bias = '0;
        endcase
        return bias;
    endfunction

endpackage

// File: rtl/float_unorm_quant.sv
// One colour channel of the formatter: classifies a single-precision float,
// aligns it to an unsigned fixed-point fraction, adds the quantisation bias
// and clamps to OUT_BITS. Three register stages, all advancing on ce so the
// channel stays in lockstep with the valid/sideband pipe in the top level.
module float_unorm_quant
    import rgb_fmt_pkg::*;
#(
    parameter int OUT_BITS = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   ce,
    input  logic [FP_W-1:0]        f_val,
    input  logic [BIAS_FRAC_W-1:0] bias,
    output logic [OUT_BITS-1:0]    code,
    output logic                   sat
);

    // Fraction of v kept after alignment: OUT_BITS code bits plus guard bits.
    localparam int FRAC_W = OUT_BITS + BIAS_FRAC_W;

    // Exponent of 1.0; anything at or above this clamps high.
    localparam logic [FP_EXP_W-1:0] EXP_ONE = FP_EXP_W'(FP_EXP_BIAS);
    // Smallest exponent whose leading one still lands inside the fraction.
    localparam logic [FP_EXP_W-1:0] EXP_MIN = FP_EXP_W'(FP_EXP_BIAS - FRAC_W);
    // Right shift of {1,mantissa} is SHIFT_BASE - exp. FRAC_W never exceeds
    // the 23 mantissa bits, so for exp < 127 this is always a right shift.
    localparam logic [FP_EXP_W-1:0] SHIFT_BASE = FP_EXP_W'(FP_EXP_BIAS + FP_MAN_W - FRAC_W);

    logic                  sign_f;
    logic [FP_EXP_W-1:0]   exp_f;
    logic [FP_MAN_W-1:0]   man_f;
    logic                  is_nan;
    logic [FP_MAN_W:0]     mant;
    logic [FP_EXP_W-1:0]   rshift_c;
    logic [FRAC_W-1:0]     frac_c;
    logic                  force_sat_c;

    logic [FRAC_W-1:0]     frac_s1;
    logic                  force_sat_s1;

    logic [FRAC_W:0]       sum_c;
    logic [OUT_BITS-1:0]   int_c;
    logic                  sat_c;

    logic [OUT_BITS-1:0]   int_s2;
    logic                  sat_s2;

    assign sign_f = f_val[FP_W-1];
    assign exp_f  = f_val[FP_W-2 -: FP_EXP_W];
    assign man_f  = f_val[FP_MAN_W-1:0];
    assign is_nan = (exp_f == '1) && (man_f != '0);
    assign mant   = {1'b1, man_f};

    // Classify the float and align its significand into the fixed-point fraction.
    always_comb begin
        frac_c      = '0;
        force_sat_c = 1'b0;
        rshift_c    = SHIFT_BASE - exp_f;
        if (sign_f || is_nan || (exp_f == '0)) begin
            frac_c = '0;
        end else if (exp_f >= EXP_ONE) begin
            force_sat_c = 1'b1;
        end else if (exp_f >= EXP_MIN) begin
            frac_c = FRAC_W'(mant >> rshift_c);
        end
    end

    // Stage 1: aligned fraction and the "already at or above 1.0" flag.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            frac_s1      <= '0;
            force_sat_s1 <= 1'b0;
        end else if (ce) begin
            frac_s1      <= frac_c;
            force_sat_s1 <= force_sat_c;
        end
    end

    // Add the bias; a carry out of the fraction means the clamp must engage.
    always_comb begin
        sum_c = {1'b0, frac_s1} + (FRAC_W + 1)'(bias);
        int_c = OUT_BITS'(sum_c >> BIAS_FRAC_W);
        sat_c = force_sat_s1 | sum_c[FRAC_W];
    end

    // Stage 2: floored code and saturate flag.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            int_s2 <= '0;
            sat_s2 <= 1'b0;
        end else if (ce) begin
            int_s2 <= int_c;
            sat_s2 <= sat_c;
        end
    end

    // Stage 3: clamp to full scale and register the channel outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            code <= '0;
            sat  <= 1'b0;
        end else if (ce) begin
            code <= sat_s2 ? '1 : int_s2;
            sat  <= sat_s2;
        end
    end

endmodule

// File: rtl/rgb_float_quantize.sv
// Float colour to unorm pixel formatter. NUM_CH channels are quantised in
// parallel by float_unorm_quant instances; this level carries valid, x, y,
// visible and mode alongside them, applies valid/ready backpressure as a
// whole-pipe clock enable and counts pixels that clamped high.
module rgb_float_quantize
    import rgb_fmt_pkg::*;
#(
    parameter int NUM_CH    = 3,
    parameter int OUT_BITS  = 4,
    parameter int X_W       = 11,
    parameter int Y_W       = 10,
    parameter int SAT_CNT_W = 16
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [NUM_CH*32-1:0]       ch_in,
    input  logic [X_W-1:0]             x_in,
    input  logic [Y_W-1:0]             y_in,
    input  logic                       visible_in,
    input  logic [1:0]                 mode_in,
    input  logic                       valid_in,
    output logic                       ready_out,
    output logic [NUM_CH*OUT_BITS-1:0] ch_out,
    output logic [X_W-1:0]             x_out,
    output logic [Y_W-1:0]             y_out,
    output logic                       visible_out,
    output logic                       valid_out,
    input  logic                       ready_in,
    input  logic                       sat_clr,
    output logic [SAT_CNT_W-1:0]       sat_count
);

    logic                   ce;

    logic                   valid_s1;
    logic [X_W-1:0]         x_s1;
    logic [Y_W-1:0]         y_s1;
    logic                   visible_s1;
    logic [1:0]             mode_s1;

    logic                   valid_s2;
    logic [X_W-1:0]         x_s2;
    logic [Y_W-1:0]         y_s2;
    logic                   visible_s2;

    logic [BIAS_FRAC_W-1:0] bias_s1;
    logic [NUM_CH-1:0]      ch_sat;
    logic                   pixel_sat;
    logic                   count_evt;

    // The pipe only stalls when a finished pixel is waiting on the consumer,
    // so ready_out never depends on valid_in.
    assign ce        = !valid_out || ready_in;
    assign ready_out = ce;

    // Bias is chosen from the pixel's own mode and coordinates one stage in,
    // so it meets the channel data exactly where the bias is added.
    assign bias_s1 = quant_bias(mode_s1, x_s1[0], y_s1[0]);

    // Valid and sideband pipe, advancing in step with the channel datapaths.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_s1    <= 1'b0;
            x_s1        <= '0;
            y_s1        <= '0;
            visible_s1  <= 1'b0;
            mode_s1     <= Q_TRUNC;
            valid_s2    <= 1'b0;
            x_s2        <= '0;
            y_s2        <= '0;
            visible_s2  <= 1'b0;
            valid_out   <= 1'b0;
            x_out       <= '0;
            y_out       <= '0;
            visible_out <= 1'b0;
        end else if (ce) begin
            valid_s1    <= valid_in;
            x_s1        <= x_in;
            y_s1        <= y_in;
            visible_s1  <= visible_in;
            mode_s1     <= mode_in;
            valid_s2    <= valid_s1;
            x_s2        <= x_s1;
            y_s2        <= y_s1;
            visible_s2  <= visible_s1;
            valid_out   <= valid_s2;
            x_out       <= x_s2;
            y_out       <= y_s2;
            visible_out <= visible_s2;
        end
    end

    // One quantiser per colour channel; channel 0 lives in the low bits.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        float_unorm_quant #(
            .OUT_BITS (OUT_BITS)
        ) u_quant (
            .clk_in (clk_in),
            .rst_in (rst_in),
            .ce     (ce),
            .f_val  (ch_in[i*32 +: 32]),
            .bias   (bias_s1),
            .code   (ch_out[i*OUT_BITS +: OUT_BITS]),
            .sat    (ch_sat[i])
        );
    end

    assign pixel_sat = |ch_sat;
    assign count_evt = valid_out && ready_in && pixel_sat;

    // Saturated-pixel counter: counts on hand-off, sticks at full scale,
    // and a clear wins over a same-cycle count.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sat_count <= '0;
        end else if (sat_clr) begin
            sat_count <= '0;
        end else if (count_evt && (sat_count != '1)) begin
            sat_count <= sat_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_rgb_float_quantize.sv
// Directed bench for rgb_float_quantize: a 3x4-bit instance for the main
// behaviour and a 1x8-bit instance with a 2-bit counter for the parameter
// sweep and the counter's sticky ceiling.
module tb_rgb_float_quantize;
    import rgb_fmt_pkg::*;

    logic        clk_in;
    logic        rst_in;

    logic [95:0] ch_in;
    logic [10:0] x_in;
    logic [9:0]  y_in;
    logic        visible_in;
    logic [1:0]  mode_in;
    logic        valid_in;
    logic        ready_out;
    logic [11:0] ch_out;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic        visible_out;
    logic        valid_out;
    logic        ready_in;
    logic        sat_clr;
    logic [15:0] sat_count;

    logic [31:0] ch8_in;
    logic [10:0] x8_in;
    logic [9:0]  y8_in;
    logic        vis8_in;
    logic [1:0]  mode8_in;
    logic        valid8_in;
    logic        ready8_out;
    logic [7:0]  ch8_out;
    logic [10:0] x8_out;
    logic [9:0]  y8_out;
    logic        vis8_out;
    logic        valid8_out;
    logic        ready8_in;
    logic        sat8_clr;
    logic [1:0]  sat8_count;

    int n_cmp;
    int n_fail;
    int exp_sat;

    rgb_float_quantize #(
        .NUM_CH(3), .OUT_BITS(4), .X_W(11), .Y_W(10), .SAT_CNT_W(16)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .ch_in(ch_in), .x_in(x_in), .y_in(y_in),
        .visible_in(visible_in), .mode_in(mode_in), .valid_in(valid_in),
        .ready_out(ready_out), .ch_out(ch_out), .x_out(x_out), .y_out(y_out),
        .visible_out(visible_out), .valid_out(valid_out), .ready_in(ready_in),
        .sat_clr(sat_clr), .sat_count(sat_count)
    );

    rgb_float_quantize #(
        .NUM_CH(1), .OUT_BITS(8), .X_W(11), .Y_W(10), .SAT_CNT_W(2)
    ) dut8 (
        .clk_in(clk_in), .rst_in(rst_in), .ch_in(ch8_in), .x_in(x8_in), .y_in(y8_in),
        .visible_in(vis8_in), .mode_in(mode8_in), .valid_in(valid8_in),
        .ready_out(ready8_out), .ch_out(ch8_out), .x_out(x8_out), .y_out(y8_out),
        .visible_out(vis8_out), .valid_out(valid8_out), .ready_in(ready8_in),
        .sat_clr(sat8_clr), .sat_count(sat8_count)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Advance one clock and settle just past the edge.
    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    // Present one pixel to the 3-channel instance and wait for it to come out.
    task automatic run_pixel(input logic [95:0] ch, input logic [10:0] x, input logic [9:0] y,
                             input logic vis, input logic [1:0] mode, output int lat);
        ch_in = ch; x_in = x; y_in = y; visible_in = vis; mode_in = mode;
        valid_in = 1'b1; ready_in = 1'b1;
        tick;
        valid_in = 1'b0;
        lat = 1;
        while (!valid_out && lat < 10) begin
            tick;
            lat++;
        end
        if (!valid_out) lat = -1;
    endtask

    // Same for the 1-channel 8-bit instance.
    task automatic run_pixel8(input logic [31:0] ch, input logic [1:0] mode, output int lat);
        ch8_in = ch; mode8_in = mode; x8_in = 11'd3; y8_in = 10'd4; vis8_in = 1'b1;
        valid8_in = 1'b1; ready8_in = 1'b1;
        tick;
        valid8_in = 1'b0;
        lat = 1;
        while (!valid8_out && lat < 10) begin
            tick;
            lat++;
        end
        if (!valid8_out) lat = -1;
    endtask

    task automatic test_reset;
        rst_in = 1'b1; ready_in = 1'b0;
        tick; tick;
        n_cmp++; if (valid_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b need 0", valid_out); end
        n_cmp++; if (ch_out !== 12'h000) begin n_fail++; $display("[TB] FAIL reset_ch: got %h need 000", ch_out); end
        n_cmp++; if (x_out !== 11'd0 || y_out !== 10'd0 || visible_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_side: got x=%0d y=%0d v=%b need 0", x_out, y_out, visible_out); end
        n_cmp++; if (sat_count !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_sat: got %0d need 0", sat_count); end
        n_cmp++; if (ready_out !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b need 1", ready_out); end
        #2 rst_in = 1'b0;
        ready_in = 1'b1;
        tick;
        exp_sat = 0;
    endtask

    task automatic test_basic;
        int lat;
        run_pixel({32'h3F800000, 32'h3E800000, 32'h3F000000}, 11'd5, 10'd7, 1'b1, Q_TRUNC, lat);
        n_cmp++; if (lat !== 3) begin n_fail++; $display("[TB] FAIL basic_latency: got %0d need 3", lat); end
        n_cmp++; if (ch_out !== 12'hF48) begin n_fail++; $display("[TB] FAIL basic_ch: got %h need F48", ch_out); end
        n_cmp++; if (x_out !== 11'd5 || y_out !== 10'd7 || visible_out !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_side: got x=%0d y=%0d v=%b need 5 7 1", x_out, y_out, visible_out); end
        tick;
        exp_sat++;
        n_cmp++; if (sat_count !== 16'(exp_sat)) begin n_fail++; $display("[TB] FAIL basic_sat: got %0d need %0d", sat_count, exp_sat); end
    endtask

    task automatic test_special;
        int lat;
        run_pixel({32'h00000000, 32'h7FC00000, 32'hBF000000}, 11'd1, 10'd1, 1'b0, Q_TRUNC, lat);
        n_cmp++; if (ch_out !== 12'h000) begin n_fail++; $display("[TB] FAIL special_zero_nan_neg: got %h need 000", ch_out); end
        tick;
        n_cmp++; if (sat_count !== 16'(exp_sat)) begin n_fail++; $display("[TB] FAIL special_sat_hold: got %0d need %0d", sat_count, exp_sat); end
        // Denormal, -0, +Inf.
        run_pixel({32'h00400000, 32'h80000000, 32'h7F800000}, 11'd2, 10'd2, 1'b1, Q_TRUNC, lat);
        n_cmp++; if (ch_out !== 12'h00F) begin n_fail++; $display("[TB] FAIL special_inf: got %h need 00F", ch_out); end
        tick;
        exp_sat++;
        n_cmp++; if (sat_count !== 16'(exp_sat)) begin n_fail++; $display("[TB] FAIL special_inf_sat: got %0d need %0d", sat_count, exp_sat); end
        // -Inf, -NaN, and a value below the alignment window, all in round mode.
        run_pixel({32'hFF800000, 32'hFFC00000, 32'h38000000}, 11'd3, 10'd3, 1'b0, Q_ROUND, lat);
        n_cmp++; if (ch_out !== 12'h000) begin n_fail++; $display("[TB] FAIL special_neg_inf_tiny: got %h need 000", ch_out); end
        tick;
        n_cmp++; if (sat_count !== 16'(exp_sat)) begin n_fail++; $display("[TB] FAIL special_sat_hold2: got %0d need %0d", sat_count, exp_sat); end
    endtask

    task automatic test_modes;
        // 0.53125 * 16 = 8.5; dither biases 0, 2/4, 3/4, 1/4 for {y0,x0} = 00, 01, 10, 11.
        logic [1:0]  m_tab[7] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
        logic [10:0] x_tab[7] = '{11'd0, 11'd0, 11'd0, 11'd1, 11'd0, 11'd1, 11'd0};
        logic [9:0]  y_tab[7] = '{10'd0, 10'd0, 10'd0, 10'd0, 10'd1, 10'd1, 10'd0};
        logic [11:0] e_tab[7] = '{12'h888, 12'h999, 12'h888, 12'h999, 12'h999, 12'h888, 12'h888};
        int lat;
        for (int i = 0; i < 7; i++) begin
            run_pixel({3{32'h3F080000}}, x_tab[i], y_tab[i], 1'b1, m_tab[i], lat);
            n_cmp++; if (ch_out !== e_tab[i]) begin n_fail++; $display("[TB] FAIL mode_%0d: got %h need %h", i, ch_out, e_tab[i]); end
        end
        // 0.984375 * 16 = 15.75: round clamps (saturated), truncate gives 15 unclamped.
        run_pixel({3{32'h3F7C0000}}, 11'd0, 10'd0, 1'b1, Q_ROUND, lat);
        n_cmp++; if (ch_out !== 12'hFFF) begin n_fail++; $display("[TB] FAIL mode_round_clamp: got %h need FFF", ch_out); end
        tick;
        exp_sat++;
        n_cmp++; if (sat_count !== 16'(exp_sat)) begin n_fail++; $display("[TB] FAIL mode_round_sat: got %0d need %0d", sat_count, exp_sat); end
        run_pixel({3{32'h3F7C0000}}, 11'd0, 10'd0, 1'b1, Q_TRUNC, lat);
        n_cmp++; if (ch_out !== 12'hFFF) begin n_fail++; $display("[TB] FAIL mode_trunc_15: got %h need FFF", ch_out); end
        tick;
        n_cmp++; if (sat_count !== 16'(exp_sat)) begin n_fail++; $display("[TB] FAIL mode_trunc_nosat: got %0d need %0d", sat_count, exp_sat); end
    endtask

    task automatic test_backpressure;
        logic [31:0] vals[10]  = '{32'h3D800000, 32'h3E000000, 32'h3E800000, 32'h3F000000, 32'h3E400000,
                                   32'h3EC00000, 32'h3F400000, 32'h3F600000, 32'h3F200000, 32'h3EA00000};
        logic [3:0]  codes[10] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd6, 4'd12, 4'd14, 4'd10, 4'd5};
        int          sent = 0;
        int          recvd = 0;
        int          cyc = 0;
        int          extra = 0;
        bit          stalled_prev = 0;
        bit          accept;
        logic [11:0] held_ch = '0;
        logic [10:0] held_x = '0;
        mode_in = Q_TRUNC; visible_in = 1'b0;
        while (recvd < 10 && cyc < 200) begin
            ready_in = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            if (sent < 10) begin
                valid_in = 1'b1;
                ch_in = {64'd0, vals[sent]};
                x_in = 11'(sent);
                y_in = 10'(sent + 100);
            end else begin
                valid_in = 1'b0;
            end
            #1;
            if (stalled_prev) begin
                n_cmp++;
                if (valid_out !== 1'b1 || ch_out !== held_ch || x_out !== held_x) begin
                    n_fail++; $display("[TB] FAIL bp_hold: got v=%b ch=%h x=%0d need 1 %h %0d", valid_out, ch_out, x_out, held_ch, held_x);
                end
            end
            stalled_prev = 0;
            if (valid_out && ready_in) begin
                n_cmp++;
                if (x_out !== 11'(recvd) || y_out !== 10'(recvd + 100) || ch_out !== {8'd0, codes[recvd]}) begin
                    n_fail++; $display("[TB] FAIL bp_pixel_%0d: got x=%0d y=%0d ch=%h need %0d %0d %h", recvd, x_out, y_out, ch_out, recvd, recvd + 100, {8'd0, codes[recvd]});
                end
                recvd++;
            end else if (valid_out) begin
                stalled_prev = 1;
                held_ch = ch_out;
                held_x = x_out;
            end
            accept = valid_in && ready_out;
            tick;
            if (accept) sent++;
            cyc++;
        end
        valid_in = 1'b0; ready_in = 1'b1;
        n_cmp++; if (recvd != 10) begin n_fail++; $display("[TB] FAIL bp_count: got %0d need 10", recvd); end
        for (int i = 0; i < 5; i++) begin
            if (valid_out) extra++;
            tick;
        end
        n_cmp++; if (extra != 0) begin n_fail++; $display("[TB] FAIL bp_extra: got %0d need 0", extra); end
    endtask

    task automatic test_sat_clr;
        int lat;
        run_pixel({64'd0, 32'h3F800000}, 11'd9, 10'd9, 1'b1, Q_TRUNC, lat);
        tick;
        exp_sat++;
        n_cmp++; if (sat_count !== 16'(exp_sat)) begin n_fail++; $display("[TB] FAIL clr_pre: got %0d need %0d", sat_count, exp_sat); end
        run_pixel({64'd0, 32'h3F800000}, 11'd9, 10'd9, 1'b1, Q_TRUNC, lat);
        sat_clr = 1'b1;
        tick;
        sat_clr = 1'b0;
        exp_sat = 0;
        n_cmp++; if (sat_count !== 16'd0) begin n_fail++; $display("[TB] FAIL clr_priority: got %0d need 0", sat_count); end
    endtask

    task automatic test_reset_midstream;
        int lat;
        int stale = 0;
        run_pixel({64'd0, 32'h3F800000}, 11'd1, 10'd1, 1'b1, Q_TRUNC, lat);
        tick;
        exp_sat++;
        ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ch_in = {64'd0, 32'h3F800000}; x_in = 11'(20 + i); y_in = 10'd0;
            valid_in = 1'b1;
            tick;
        end
        valid_in = 1'b0;
        #2 rst_in = 1'b1;
        #1;
        n_cmp++; if (valid_out !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_valid: got %b need 0", valid_out); end
        n_cmp++; if (sat_count !== 16'd0) begin n_fail++; $display("[TB] FAIL mid_reset_sat: got %0d need 0", sat_count); end
        tick; tick;
        #2 rst_in = 1'b0;
        exp_sat = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (valid_out) stale++;
        end
        n_cmp++; if (stale != 0) begin n_fail++; $display("[TB] FAIL mid_stale: got %0d need 0", stale); end
        run_pixel({64'd0, 32'h3F000000}, 11'd30, 10'd31, 1'b1, Q_TRUNC, lat);
        n_cmp++; if (lat !== 3 || ch_out !== 12'h008 || x_out !== 11'd30) begin n_fail++; $display("[TB] FAIL mid_first: got lat=%0d ch=%h x=%0d need 3 008 30", lat, ch_out, x_out); end
        tick;
    endtask

    task automatic test_param_sweep;
        int lat;
        run_pixel8(32'h3F000000, Q_TRUNC, lat);
        n_cmp++; if (lat !== 3 || ch8_out !== 8'd128) begin n_fail++; $display("[TB] FAIL p8_half: got lat=%0d code=%0d need 3 128", lat, ch8_out); end
        // 0.99609375 * 256 = 255.0 exactly; +0.5 floors to 255 without clamping.
        run_pixel8(32'h3F7F0000, Q_ROUND, lat);
        n_cmp++; if (ch8_out !== 8'd255) begin n_fail++; $display("[TB] FAIL p8_round_255: got %0d need 255", ch8_out); end
        tick;
        n_cmp++; if (sat8_count !== 2'd0) begin n_fail++; $display("[TB] FAIL p8_nosat: got %0d need 0", sat8_count); end
        // 0.998046875 * 256 = 255.5; +0.5 reaches 256 and clamps.
        run_pixel8(32'h3F7F8000, Q_ROUND, lat);
        n_cmp++; if (ch8_out !== 8'd255) begin n_fail++; $display("[TB] FAIL p8_round_clamp: got %0d need 255", ch8_out); end
        tick;
        n_cmp++; if (sat8_count !== 2'd1) begin n_fail++; $display("[TB] FAIL p8_sat1: got %0d need 1", sat8_count); end
        for (int i = 2; i <= 4; i++) begin
            run_pixel8(32'h3F800000, Q_TRUNC, lat);
            tick;
            n_cmp++;
            if (sat8_count !== ((i > 3) ? 2'd3 : 2'(i))) begin
                n_fail++; $display("[TB] FAIL p8_sticky_%0d: got %0d need %0d", i, sat8_count, (i > 3) ? 3 : i);
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; exp_sat = 0;
        rst_in = 1'b1;
        ch_in = '0; x_in = '0; y_in = '0; visible_in = 1'b0; mode_in = 2'd0;
        valid_in = 1'b0; ready_in = 1'b0; sat_clr = 1'b0;
        ch8_in = '0; x8_in = '0; y8_in = '0; vis8_in = 1'b0; mode8_in = 2'd0;
        valid8_in = 1'b0; ready8_in = 1'b1; sat8_clr = 1'b0;
        #1;
        test_reset;
        test_basic;
        test_special;
        test_modes;
        test_backpressure;
        test_sat_clr;
        test_reset_midstream;
        test_param_sweep;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
